// File: rtl/rgb_fade_sequencer.sv
// RGB palette fader: walks a 6-colour palette, ramping each PWM duty
// word linearly toward the next colour and holding it for a while.
module rgb_fade_sequencer #(
  parameter int PWM_RESOLUTION_BITS = 8,
  parameter int TICK_DIV            = 12000,
  parameter int HOLD_TICKS          = 256,
  parameter int STEP_SIZE           = 1
) (
  input  logic                           CLK_IP,
  input  logic                           RST_IP,
  input  logic                           enable,
  input  logic                           advance,
  output logic [PWM_RESOLUTION_BITS-1:0] red_val,
  output logic [PWM_RESOLUTION_BITS-1:0] green_val,
  output logic [PWM_RESOLUTION_BITS-1:0] blue_val,
  output logic                           pwm_en,
  output logic [2:0]                     color_idx,
  output logic                           ramping,
  output logic                           wrap
);

  localparam int W  = PWM_RESOLUTION_BITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [W-1:0]  LVL      = W'(150);
  localparam logic [W-1:0]  STEP_V   = W'(STEP_SIZE);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [W-1:0]  red_d, green_d, blue_d;
  logic [W-1:0]  red_t, green_t, blue_t;
  logic          pwm_d, wrap_d;
  logic [2:0]    idx_d;
  logic          tick, expire;

  // palette as an on-mask {r,g,b}; every lit channel sits at level 150
  function automatic logic [2:0] pal_mask(input logic [2:0] idx);
    unique case (idx)
      3'd0:    pal_mask = 3'b100;
      3'd1:    pal_mask = 3'b110;
      3'd2:    pal_mask = 3'b010;
      3'd3:    pal_mask = 3'b011;
      3'd4:    pal_mask = 3'b001;
      3'd5:    pal_mask = 3'b101;
      default: pal_mask = 3'b000;
    endcase
  endfunction

  // one linear step toward target, snapping when within a step
  function automatic logic [W-1:0] step_to(
    input logic [W-1:0] cur,
    input logic [W-1:0] tgt
  );
    if (cur < tgt) begin
      step_to = ((tgt - cur) <= STEP_V) ? tgt : cur + STEP_V;
    end else begin
      step_to = ((cur - tgt) <= STEP_V) ? tgt : cur - STEP_V;
    end
  endfunction

  assign red_t   = pal_mask(color_idx)[2] ? LVL : '0;
  assign green_t = pal_mask(color_idx)[1] ? LVL : '0;
  assign blue_t  = pal_mask(color_idx)[0] ? LVL : '0;
  assign tick    = (pre_q == PRE_LAST);

  // next-state, prescaler, hold counter and output computation
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    hold_d  = hold_q;
    red_d   = red_val;
    green_d = green_val;
    blue_d  = blue_val;
    pwm_d   = pwm_en;
    idx_d   = color_idx;
    wrap_d  = 1'b0;
    expire  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      pre_d   = '0;
      hold_d  = '0;
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      pwm_d   = 1'b0;
      idx_d   = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RAMP;
          pwm_d   = 1'b1;
          pre_d   = '0;
          hold_d  = '0;
          idx_d   = 3'd0;
        end
        RAMP, HOLD: begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          if (state_q == RAMP && tick) begin
            red_d   = step_to(red_val, red_t);
            green_d = step_to(green_val, green_t);
            blue_d  = step_to(blue_val, blue_t);
            if (red_d == red_t && green_d == green_t
                && blue_d == blue_t) begin
              state_d = HOLD;
              hold_d  = '0;
            end
          end
          if (state_q == HOLD && tick) begin
            if (hold_q == HOLD_LAST) expire = 1'b1;
            else hold_d = hold_q + HW'(1);
          end
          if (advance || expire) begin
            idx_d   = (color_idx == 3'd5) ? 3'd0 : color_idx + 3'd1;
            wrap_d  = (color_idx == 3'd5);
            state_d = RAMP;
            hold_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge CLK_IP or posedge RST_IP) begin
    if (RST_IP) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      hold_q    <= '0;
      red_val   <= '0;
      green_val <= '0;
      blue_val  <= '0;
      pwm_en    <= 1'b0;
      color_idx <= 3'd0;
      ramping   <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      hold_q    <= hold_d;
      red_val   <= red_d;
      green_val <= green_d;
      blue_val  <= blue_d;
      pwm_en    <= pwm_d;
      color_idx <= idx_d;
      ramping   <= (state_d == RAMP);
      wrap      <= wrap_d;
    end
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: two instances (step 50 and step 7)
// compared every cycle against a cycle-level palette model.
module tb_rgb_fade_sequencer;

  localparam int TD = 4;
  localparam int HT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic advance = 1'b0;

  logic [7:0] red1, green1, blue1, red2, green2, blue2;
  logic       pwm1, ramp1, wrap1, pwm2, ramp2, wrap2;
  logic [2:0] idx1, idx2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(
    .PWM_RESOLUTION_BITS(8), .TICK_DIV(TD),
    .HOLD_TICKS(HT), .STEP_SIZE(50)
  ) d1 (
    .CLK_IP(clk), .RST_IP(rst), .enable(enable), .advance(advance),
    .red_val(red1), .green_val(green1), .blue_val(blue1),
    .pwm_en(pwm1), .color_idx(idx1), .ramping(ramp1), .wrap(wrap1)
  );

  rgb_fade_sequencer #(
    .PWM_RESOLUTION_BITS(8), .TICK_DIV(TD),
    .HOLD_TICKS(HT), .STEP_SIZE(7)
  ) d2 (
    .CLK_IP(clk), .RST_IP(rst), .enable(enable), .advance(advance),
    .red_val(red2), .green_val(green2), .blue_val(blue2),
    .pwm_en(pwm2), .color_idx(idx2), .ramping(ramp2), .wrap(wrap2)
  );

  wire [29:0] got1 = {red1, green1, blue1, pwm1, idx1, ramp1, wrap1};
  wire [29:0] got2 = {red2, green2, blue2, pwm2, idx2, ramp2, wrap2};

  // mode: 0 dark, 1 ramping, 2 holding
  typedef struct packed {
    int mode;
    int pre;
    int hold;
    int r;
    int g;
    int b;
    int idx;
    bit pwm;
    bit wrap;
  } mdl_t;

  mdl_t m1, m2;

  function automatic int pal(int idx, int ch);
    int mask;
    case (idx)
      0: mask = 4;
      1: mask = 6;
      2: mask = 2;
      3: mask = 3;
      4: mask = 1;
      default: mask = 5;
    endcase
    return ((mask >> (2 - ch)) & 1) != 0 ? 150 : 0;
  endfunction

  function automatic int toward(int cur, int tgt, int s);
    int d = tgt - cur;
    if (d <= s && d >= -s) return tgt;
    return (d > 0) ? cur + s : cur - s;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit en, bit adv, int s);
    mdl_t n = m;
    bit tick, expd;
    n.wrap = 1'b0;
    if (!en) begin
      n = '0;
      return n;
    end
    if (m.mode == 0) begin
      n.mode = 1;
      n.pwm = 1'b1;
      n.pre = 0;
      n.hold = 0;
      return n;
    end
    tick = (m.pre == TD - 1);
    n.pre = (m.pre + 1) % TD;
    expd = 1'b0;
    if (m.mode == 1 && tick) begin
      n.r = toward(m.r, pal(m.idx, 0), s);
      n.g = toward(m.g, pal(m.idx, 1), s);
      n.b = toward(m.b, pal(m.idx, 2), s);
      if (n.r == pal(m.idx, 0) && n.g == pal(m.idx, 1)
          && n.b == pal(m.idx, 2)) begin
        n.mode = 2;
        n.hold = 0;
      end
    end
    if (m.mode == 2 && tick) begin
      if (m.hold == HT - 1) expd = 1'b1;
      else n.hold = m.hold + 1;
    end
    if (adv || expd) begin
      n.wrap = (m.idx == 5);
      n.idx = (m.idx + 1) % 6;
      n.mode = 1;
      n.hold = 0;
    end
    return n;
  endfunction

  function automatic logic [29:0] exp_vec(mdl_t m);
    return {m.r[7:0], m.g[7:0], m.b[7:0], m.pwm,
            m.idx[2:0], m.mode == 1, m.wrap};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= '0;
      m2 <= '0;
    end else begin
      m1 <= mstep(m1, enable, advance, 50);
      m2 <= mstep(m2, enable, advance, 7);
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (got1 !== 30'h0 || got2 !== 30'h0) begin
      errors++;
      $display("FAIL reset_init got %h/%h want 0", got1, got2);
    end
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (got1 !== 30'h0 || got2 !== 30'h0) begin
      errors++;
      $display("FAIL reset_async got %h/%h want 0", got1, got2);
    end
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (got1 !== 30'h0 || pwm1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got %h want 0", got1);
    end
  endtask

  task automatic test_ramp_red();
    @(negedge clk);
    enable = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (got1 !== exp_vec(m1) || got2 !== exp_vec(m2)) begin
        errors++;
        $display("FAIL ramp_model c=%0d got %h/%h want %h/%h",
                 c, got1, got2, exp_vec(m1), exp_vec(m2));
      end
      if (c == 1) begin
        checks++;
        if (pwm1 !== 1'b1 || ramp1 !== 1'b1) begin
          errors++;
          $display("FAIL ramp_start pwm=%b ramp=%b want 1 1",
                   pwm1, ramp1);
        end
      end
      if (c == 5 || c == 9 || c == 13) begin
        checks++;
        if (red1 !== 8'((c - 1) / 4 * 50)) begin
          errors++;
          $display("FAIL ramp_red c=%0d got %0d want %0d",
                   c, red1, (c - 1) / 4 * 50);
        end
      end
      if (c == 13) begin
        checks++;
        if (ramp1 !== 1'b0) begin
          errors++;
          $display("FAIL ramp_hold got ramping=%b want 0", ramp1);
        end
      end
      if (c == 21) begin
        checks++;
        if (idx1 !== 3'd1 || ramp1 !== 1'b1) begin
          errors++;
          $display("FAIL hold_expire got idx=%0d want 1", idx1);
        end
      end
      if (c == 25) begin
        checks++;
        if (green1 !== 8'd50) begin
          errors++;
          $display("FAIL green_step got %0d want 50", green1);
        end
      end
    end
  endtask

  task automatic test_full_sequence();
    bit found = 1'b0;
    int blues[$];
    int want[$] = '{100, 50, 0};
    int last;
    int wraps = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (got1 !== exp_vec(m1) || got2 !== exp_vec(m2)) begin
        errors++;
        $display("FAIL seq_model c=%0d got %h want %h",
                 c, got1, exp_vec(m1));
      end
      if (wrap1 === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || idx1 !== 3'd0 || red1 !== 8'd150
        || blue1 !== 8'd150) begin
      errors++;
      $display("FAIL wrap_seen found=%0d idx=%0d r=%0d b=%0d",
               found, idx1, red1, blue1);
    end
    last = blue1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (wrap1 === 1'b1) wraps++;
      if (blue1 != last) begin
        blues.push_back(blue1);
        last = blue1;
      end
    end
    checks++;
    if (wraps != 0) begin
      errors++;
      $display("FAIL wrap_width extra pulses %0d want 0", wraps);
    end
    checks++;
    if (blues != want || red1 !== 8'd150) begin
      errors++;
      $display("FAIL wrap_blue got %p red=%0d want %p red=150",
               blues, red1, want);
    end
  endtask

  task automatic test_advance();
    bit hit = 1'b0;
    bit ramp_ok = 1'b1;
    bit done = 1'b0;
    pulse_reset();
    for (int c = 0; c < 40 && !hit; c++) begin
      @(posedge clk);
      #1;
      if (red1 === 8'd100) hit = 1'b1;
    end
    @(negedge clk);
    advance = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (!hit || idx1 !== 3'd1 || ramp1 !== 1'b1) begin
      errors++;
      $display("FAIL adv_idx got idx=%0d ramp=%b want 1 1",
               idx1, ramp1);
    end
    @(negedge clk);
    advance = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (got1 !== exp_vec(m1) || got2 !== exp_vec(m2)) begin
        errors++;
        $display("FAIL adv_model c=%0d got %h want %h",
                 c, got1, exp_vec(m1));
      end
      if (red1 === 8'd150 && green1 === 8'd150) done = 1'b1;
      else if (ramp1 !== 1'b1) ramp_ok = 1'b0;
    end
    checks++;
    if (!done || !ramp_ok || ramp1 !== 1'b0) begin
      errors++;
      $display("FAIL adv_ramp done=%0d ramp_ok=%0d ramping=%b",
               done, ramp_ok, ramp1);
    end
  endtask

  task automatic test_enable_drop();
    bit hit = 1'b0;
    pulse_reset();
    for (int c = 0; c < 60 && !hit; c++) begin
      @(posedge clk);
      #1;
      if (green1 === 8'd100) hit = 1'b1;
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (!hit || got1 !== 30'h0) begin
      errors++;
      $display("FAIL en_drop hit=%0d got %h want 0", hit, got1);
    end
    @(negedge clk);
    enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (idx1 !== 3'd0 || pwm1 !== 1'b1 || red1 !== 8'd50
        || green1 !== 8'd0) begin
      errors++;
      $display("FAIL en_restart idx=%0d pwm=%b r=%0d g=%0d",
               idx1, pwm1, red1, green1);
    end
  endtask

  task automatic test_step7();
    int vals[$];
    int want[$];
    int last = 0;
    int old;
    bit hit = 1'b0;
    for (int v = 7; v < 150; v += 7) want.push_back(v);
    want.push_back(150);
    pulse_reset();
    for (int c = 0; c < 120 && red2 != 8'd150; c++) begin
      @(posedge clk);
      #1;
      if (red2 > 150) break;
      if (red2 != last) begin
        vals.push_back(red2);
        last = red2;
      end
    end
    checks++;
    if (vals != want) begin
      errors++;
      $display("FAIL step7 got %p want %p", vals, want);
    end
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (m1.mode == 2 && m1.pre == TD - 1 && m1.hold == HT - 1)
        hit = 1'b1;
    end
    old = idx1;
    advance = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (!hit || idx1 !== 3'((old + 1) % 6) || ramp1 !== 1'b1) begin
      errors++;
      $display("FAIL adv_expire got idx=%0d want %0d",
               idx1, (old + 1) % 6);
    end
    @(negedge clk);
    advance = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (idx1 !== 3'((old + 1) % 6)) begin
      errors++;
      $display("FAIL adv_once got idx=%0d want %0d",
               idx1, (old + 1) % 6);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      enable = ($urandom_range(99) < 97);
      advance = ($urandom_range(99) < 6);
      @(posedge clk);
      #1;
      checks++;
      if (got1 !== exp_vec(m1) || got2 !== exp_vec(m2)) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_model c=%0d got %h/%h want %h/%h",
                   c, got1, got2, exp_vec(m1), exp_vec(m2));
      end
    end
    @(negedge clk);
    advance = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_red();
    test_full_sequence();
    test_advance();
    test_enable_drop();
    test_step7();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
